// File: rtl/conv_window_gen_if.sv
// Stream-in / window-out bundle for conv_window_gen.
// The slave modport is the generator's side. The master modport is the side that feeds pixels and consumes windows.
interface conv_window_gen_if #(
  parameter int DATA_W = 32,
  parameter int KSIZE  = 5
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_W-1:0]      in_data;
  logic                          in_sof;
  logic                          win_valid;
  logic                          win_ready;
  logic [KSIZE*KSIZE*DATA_W-1:0] win_data;
  logic [4:0]                    win_row;
  logic [4:0]                    win_col;
  logic                          frame_done;
  logic                          err_sof;

  modport slave (
    input  in_valid, in_data, in_sof, win_ready,
    output in_ready, win_valid, win_data, win_row, win_col, frame_done, err_sof
  );

  modport master (
    output in_valid, in_data, in_sof, win_ready,
    input  in_ready, win_valid, win_data, win_row, win_col, frame_done, err_sof
  );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming KxK window generator: K-1 line buffers plus a KxK shift window feed one output register.
// Optional macro CWG_SOF_CHECK_EN enables the sticky err_sof frame-sync checker; otherwise err_sof is 0.
module conv_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int KSIZE  = 5,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  conv_window_gen_if.slave bus
);

  localparam logic [4:0] COL_LAST = 5'(IMG_W - 1);
  localparam logic [4:0] ROW_LAST = 5'(IMG_H - 1);
  localparam logic [4:0] K_M1     = 5'(KSIZE - 1);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  logic [4:0] row_q, row_d, col_q, col_d;
  logic [4:0] pix_row_s, pix_col_s;
  logic [1:0] state_q, state_d;
  logic       win_valid_q, win_valid_d;
  logic [4:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic       in_ready_s, in_acc_s, out_hs_s, emit_s, last_pix_s;

  logic signed [DATA_W-1:0] win_q     [KSIZE][KSIZE];
  logic signed [DATA_W-1:0] lb_q      [KSIZE-1][IMG_W];
  logic signed [DATA_W-1:0] col_new_s [KSIZE];
  logic [KSIZE*KSIZE*DATA_W-1:0] win_data_s;

  assign in_ready_s = !win_valid_q || bus.win_ready;
  assign in_acc_s   = bus.in_valid && in_ready_s;
  assign out_hs_s   = win_valid_q && bus.win_ready;

  // Position of the pixel on the bus: in_sof forces it to the frame origin.
  always_comb begin
    pix_row_s  = bus.in_sof ? 5'd0 : row_q;
    pix_col_s  = bus.in_sof ? 5'd0 : col_q;
    last_pix_s = (pix_row_s == ROW_LAST) && (pix_col_s == COL_LAST);
    emit_s     = in_acc_s && (pix_row_s >= K_M1) && (pix_col_s >= K_M1);
  end

  // Raster counters for the next expected pixel.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (in_acc_s) begin
      if (pix_col_s == COL_LAST) begin
        col_d = 5'd0;
        row_d = (pix_row_s == ROW_LAST) ? 5'd0 : pix_row_s + 5'd1;
      end else begin
        col_d = pix_col_s + 5'd1;
        row_d = pix_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // New window column: oldest buffered row on top, live pixel at the bottom.
  always_comb begin
    for (int i = 0; i < KSIZE; i++) col_new_s[i] = '0;
    for (int i = 0; i < KSIZE - 1; i++) col_new_s[i] = lb_q[KSIZE-2-i][pix_col_s];
    col_new_s[KSIZE-1] = bus.in_data;
  end

  // Output register control and frame FSM.
  always_comb begin
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    state_d     = state_q;
    if (emit_s) begin
      win_valid_d = 1'b1;
      win_row_d   = pix_row_s - K_M1;
      win_col_d   = pix_col_s - K_M1;
    end else if (out_hs_s) begin
      win_valid_d = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
    end
    if (in_acc_s) begin
      if (last_pix_s)              state_d = ST_LAST;
      else if (pix_row_s >= K_M1)  state_d = ST_RUN;
      else                         state_d = ST_FILL;
    end else if (out_hs_s && (state_q == ST_LAST)) begin
      state_d = ST_FILL;
    end else begin
      state_d = state_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= 5'd0;
      col_q       <= 5'd0;
      state_q     <= ST_FILL;
      win_valid_q <= 1'b0;
      win_row_q   <= 5'd0;
      win_col_q   <= 5'd0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  // Line-buffer chain; FILL keeps stale contents out of any emitted window, so no reset.
  always_ff @(posedge clk) begin
    if (in_acc_s) begin
      lb_q[0][pix_col_s] <= bus.in_data;
      for (int k = 1; k < KSIZE - 1; k++) lb_q[k][pix_col_s] <= lb_q[k-1][pix_col_s];
    end
  end

  // Shift window doubles as the output data register; it only moves on accept, which backpressure blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KSIZE; i++)
        for (int j = 0; j < KSIZE; j++) win_q[i][j] <= '0;
    end else if (in_acc_s) begin
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE - 1; j++) win_q[i][j] <= win_q[i][j+1];
        win_q[i][KSIZE-1] <= col_new_s[i];
      end
    end
  end

  // Pack taps row-major into the flat output bus.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE; j++)
        win_data_s[(i*KSIZE+j)*DATA_W +: DATA_W] = win_q[i][j];
  end

`ifdef CWG_SOF_CHECK_EN
  logic err_sof_q, err_sof_d, seen_frame_q, seen_frame_d, at_origin_s;

  // Sync checker: in_sof off-origin, or a missing in_sof at the origin once a full frame has passed.
  always_comb begin
    at_origin_s  = (row_q == 5'd0) && (col_q == 5'd0);
    err_sof_d    = err_sof_q;
    seen_frame_d = seen_frame_q || (in_acc_s && last_pix_s);
    if (in_acc_s && bus.in_sof && !at_origin_s) begin
      err_sof_d = 1'b1;
    end else if (in_acc_s && !bus.in_sof && at_origin_s && seen_frame_q) begin
      err_sof_d = 1'b1;
    end else begin
      err_sof_d = err_sof_q;
    end
  end

  // Sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sof_q    <= 1'b0;
      seen_frame_q <= 1'b0;
    end else begin
      err_sof_q    <= err_sof_d;
      seen_frame_q <= seen_frame_d;
    end
  end

  assign bus.err_sof = err_sof_q;
`else
  assign bus.err_sof = 1'b0;
`endif

  assign bus.in_ready   = in_ready_s;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_data   = win_data_s;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = out_hs_s && (state_q == ST_LAST);

endmodule
